// File: rtl/mem_pkg.sv
// Shared memory-system definitions: geometry defines, arbiter FSM states
// and the port-select encoding used by the arbiter and its round-robin core.
`ifndef MEMORY_SIZE_ENC
`define MEMORY_SIZE_ENC 7
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 8
`endif
`ifndef MEMORY_SIZE
`define MEMORY_SIZE 127
`endif

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_sel_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer remembers the last
// winner and only moves when the owner actually issues a grant.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    port_sel_e last;

    always_comb begin
        gnt = req;
        if (req[PORT_IF] && req[PORT_LS]) begin
            gnt = '0;
            if (last == PORT_LS) gnt[PORT_IF] = 1'b1;
            else                 gnt[PORT_LS] = 1'b1;
        end
    end

    // Reset to PORT_IF so the first tie goes to the load/store port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= PORT_IF;
        end else if (advance && (|req)) begin
            last <= gnt[PORT_LS] ? PORT_LS : PORT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter in front of a single-ported memory with a
// bidirectional data bus and configurable wait states.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned AW          = `MEMORY_SIZE_ENC + 1,
    parameter int unsigned DW          = `MEMORY_WIDTH,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned MAX_ADDR    = `MEMORY_SIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_valid,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_err,
    output logic [AW-1:0] mem_addr,
    inout  wire  [AW-1:0] mem_data,
    output logic          mrd,
    output logic          mwr
);

    localparam logic [3:0] WS        = 4'(WAIT_STATES);
    localparam logic [AW:0] LAST_ADDR = (AW + 1)'(MAX_ADDR);

    arb_state_e    state;
    port_sel_e     owner;
    logic          cur_we;
    logic          cur_err;
    logic [DW-1:0] cur_wdata;
    logic [DW-1:0] sampled;
    logic [3:0]    wait_cnt;

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          grant_now;
    logic [AW-1:0] next_addr;
    logic          next_we;
    logic          next_err;

    assign req       = {ls_req, if_req};
    assign grant_now = ((state == IDLE) || (state == RESP)) && (|req);
    assign next_addr = gnt[PORT_LS] ? ls_addr : if_addr;
    assign next_we   = gnt[PORT_LS] & ls_we;
    assign next_err  = {1'b0, next_addr} > LAST_ADDR;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (grant_now),
        .gnt     (gnt)
    );

    assign mem_data = mwr ? AW'(cur_wdata) : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= PORT_IF;
            cur_we    <= 1'b0;
            cur_err   <= 1'b0;
            cur_wdata <= '0;
            sampled   <= '0;
            wait_cnt  <= '0;
            mem_addr  <= '0;
            mrd       <= 1'b0;
            mwr       <= 1'b0;
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            ls_valid  <= 1'b0;
            if_err    <= 1'b0;
            ls_err    <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            if_gnt   <= 1'b0;
            ls_gnt   <= 1'b0;
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            if_err   <= 1'b0;
            ls_err   <= 1'b0;
            case (state)
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        mrd <= 1'b0;
                        mwr <= 1'b0;
                        if (!cur_we && !cur_err) sampled <= DW'(mem_data);
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (owner == PORT_LS) begin
                        ls_valid <= 1'b1;
                        ls_err   <= cur_err;
                        if (!cur_we && !cur_err) ls_rdata <= sampled;
                    end else begin
                        if_valid <= 1'b1;
                        if_err   <= cur_err;
                        if (!cur_err) if_rdata <= sampled;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A grant from IDLE or RESP overrides the state update above,
            // giving back-to-back transfers without an IDLE bubble.
            if (grant_now) begin
                state     <= ACCESS;
                owner     <= gnt[PORT_LS] ? PORT_LS : PORT_IF;
                if_gnt    <= gnt[PORT_IF];
                ls_gnt    <= gnt[PORT_LS];
                mem_addr  <= next_addr;
                cur_we    <= next_we;
                cur_err   <= next_err;
                cur_wdata <= ls_wdata;
                wait_cnt  <= WS;
                mrd       <= !next_we && !next_err;
                mwr       <= next_we && !next_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: three arbiters (0, 3 and 2 wait states) driven by
// directed and random traffic, checked every cycle against a transfer-level model.
module tb_mem_arbiter;

    localparam int NI = 3;
    localparam int unsigned MAXA = 127;

    typedef struct {
        int         start;
        bit         ls;
        bit         we;
        bit         ok;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int ws, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (ws=%0d): got %0h, want %0h at %0t", nm, ws, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned W = (g == 0) ? 0 : ((g == 1) ? 3 : 2);

        logic       rst;
        logic       if_req, ls_req, ls_we;
        logic [7:0] if_addr, ls_addr, ls_wdata;
        logic       if_gnt, if_valid, if_err, ls_gnt, ls_valid, ls_err, mrd, mwr;
        logic [7:0] if_rdata, ls_rdata, mem_addr;
        wire  [7:0] mem_data;
        bit         done_i = 1'b0;

        // Memory on the far side of the bus; unwritten words read as 0xFF.
        logic [7:0] bus_mem [256] = '{default: 8'hFF};
        assign mem_data = (mrd && !mwr) ? bus_mem[mem_addr] : 'z;
        always @(posedge clk) if (mwr) bus_mem[mem_addr] <= mem_data;

        mem_arbiter #(.AW(8), .DW(8), .WAIT_STATES(W), .MAX_ADDR(MAXA)) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
            .if_rdata(if_rdata), .if_err(if_err),
            .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
            .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
            .mem_addr(mem_addr), .mem_data(mem_data), .mrd(mrd), .mwr(mwr)
        );

        // Model: a grant occupies the memory for W+2 cycles; strobes in the
        // first W+1, response pulse W+2 cycles after the grant pulse.
        int         k = 0;
        int         free_at = 0;
        bit         last_ls = 1'b0;
        xfer_t      q[$];
        logic [7:0] exp_rd [2];
        logic [7:0] mmem [256] = '{default: 8'hFF};

        task automatic model_reset();
            q.delete();
            free_at   = 0;
            last_ls   = 1'b0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            if_req    = 1'b0;
            ls_req    = 1'b0;
        endtask

        task automatic cycle();
            xfer_t      x;
            bit         e_gnt [2];
            bit         e_val [2];
            bit         e_err [2];
            bit         acc, e_rd, e_wr;
            logic [7:0] e_addr, e_wd;
            bit         gr_if, gr_ls;
            @(negedge clk);
            k++;
            gr_if = 1'b0; gr_ls = 1'b0;
            if (!rst && k >= free_at && (if_req || ls_req)) begin
                x.ls    = (if_req && ls_req) ? !last_ls : ls_req;
                x.start = k;
                x.addr  = x.ls ? ls_addr : if_addr;
                x.we    = x.ls && ls_we;
                x.wdata = ls_wdata;
                x.ok    = (x.addr <= MAXA);
                if (x.ok && x.we) mmem[x.addr] = x.wdata;
                x.rdata = mmem[x.addr];
                q.push_back(x);
                free_at = k + W + 2;
                last_ls = x.ls;
                if (x.ls) gr_ls = 1'b1; else gr_if = 1'b1;
            end
            while (q.size() > 0 && q[0].start + W + 2 < k) void'(q.pop_front());
            e_gnt = '{0, 0}; e_val = '{0, 0}; e_err = '{0, 0};
            acc = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
            foreach (q[i]) begin
                if (q[i].start == k) e_gnt[q[i].ls] = 1'b1;
                if (k >= q[i].start && k <= q[i].start + W) begin
                    acc    = 1'b1;
                    e_addr = q[i].addr;
                    e_rd   = q[i].ok && !q[i].we;
                    e_wr   = q[i].ok && q[i].we;
                    e_wd   = q[i].wdata;
                end
                if (k == q[i].start + W + 2) begin
                    e_val[q[i].ls] = 1'b1;
                    e_err[q[i].ls] = !q[i].ok;
                    if (q[i].ok && !q[i].we) exp_rd[q[i].ls] = q[i].rdata;
                end
            end
            chk("if_gnt", W, if_gnt, e_gnt[0]);
            chk("ls_gnt", W, ls_gnt, e_gnt[1]);
            chk("if_valid", W, if_valid, e_val[0]);
            chk("ls_valid", W, ls_valid, e_val[1]);
            chk("mrd", W, mrd, e_rd);
            chk("mwr", W, mwr, e_wr);
            chk("if_rdata", W, if_rdata, exp_rd[0]);
            chk("ls_rdata", W, ls_rdata, exp_rd[1]);
            if (acc) chk("mem_addr", W, mem_addr, e_addr);
            if (e_wr) chk("mem_data", W, mem_data, e_wd);
            if (e_val[0]) chk("if_err", W, if_err, e_err[0]);
            if (e_val[1]) chk("ls_err", W, ls_err, e_err[1]);
            if (gr_if) if_req = 1'b0;
            if (gr_ls) ls_req = 1'b0;
        endtask

        task automatic xfer(input bit ls, input bit we, input logic [7:0] addr, input logic [7:0] wd,
                            output int lat, output int strb, output int gdel,
                            output bit err, output logic [7:0] rd);
            int k0;
            int gcyc;
            gcyc = -1; lat = -1; strb = 0; gdel = -1; err = 1'b0; rd = '0;
            k0 = k;
            if (ls) begin
                ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
            end else begin
                if_req = 1'b1; if_addr = addr;
            end
            for (int c = 0; c < 40 && lat < 0; c++) begin
                cycle();
                if (mrd || mwr) strb++;
                if ((ls ? ls_gnt : if_gnt) && gcyc < 0) begin
                    gcyc = k;
                    gdel = k - k0;
                end
                if (ls ? ls_valid : if_valid) begin
                    lat = k - gcyc;
                    err = ls ? ls_err : if_err;
                    rd  = ls ? ls_rdata : if_rdata;
                end
            end
        endtask

        function automatic logic [7:0] rand_addr();
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0) return 8'(MAXA + 1 + $urandom_range(0, 127));
            if (r == 1) return 8'(MAXA);
            return 8'($urandom_range(0, 15));
        endfunction

        task automatic drive_random();
            if (!if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_req = 1'b1; if_addr = rand_addr();
                end
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (!ls_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1));
                    ls_addr = rand_addr(); ls_wdata = 8'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                ls_req = 1'b0;
            end
        endtask

        initial begin
            int         lat, strb, gdel;
            bit         err;
            logic [7:0] rd;
            int         gk[$];
            bit         gl[$];
            bit         want_ls [4] = '{1, 0, 1, 0};

            rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
            if_addr = '0; ls_addr = '0; ls_wdata = '0;
            model_reset();
            #1;
            chk("rst_mrd", W, mrd, 0);
            chk("rst_mwr", W, mwr, 0);
            chk("rst_gnt", W, {if_gnt, ls_gnt}, 0);
            chk("rst_valid", W, {if_valid, ls_valid}, 0);
            chk("rst_err", W, {if_err, ls_err}, 0);
            chk("rst_rdata", W, {if_rdata, ls_rdata}, 0);
            repeat (3) cycle();
            rst = 1'b0;

            // Both ports held: LS wins the first tie, then strict alternation.
            if_addr = 8'h20; ls_addr = 8'h21; ls_we = 1'b0;
            if_req = 1'b1; ls_req = 1'b1;
            for (int c = 0; c < 60 && gk.size() < 4; c++) begin
                cycle();
                if (ls_gnt) begin gk.push_back(k); gl.push_back(1'b1); end
                if (if_gnt) begin gk.push_back(k); gl.push_back(1'b0); end
                if_req = 1'b1; ls_req = 1'b1;
            end
            if_req = 1'b0; ls_req = 1'b0;
            chk("alt_count", W, gk.size(), 4);
            for (int i = 0; i < gk.size() && i < 4; i++) begin
                chk("alt_port", W, gl[i], want_ls[i]);
                if (i > 0) chk("alt_spacing", W, gk[i] - gk[i-1], W + 2);
            end
            repeat (W + 4) cycle();

            xfer(1'b1, 1'b1, 8'd3, 8'h05, lat, strb, gdel, err, rd);
            chk("wr3_strobes", W, strb, W + 1);
            chk("wr3_latency", W, lat, W + 2);
            xfer(1'b1, 1'b0, 8'd3, 8'h00, lat, strb, gdel, err, rd);
            chk("rd3_latency", W, lat, W + 2);
            chk("rd3_data", W, rd, 8'h05);
            chk("rd3_err", W, err, 0);
            xfer(1'b0, 1'b0, 8'd10, 8'h00, lat, strb, gdel, err, rd);
            chk("if10_data", W, rd, 8'hFF);
            chk("if10_err", W, err, 0);
            chk("if10_strobes", W, strb, W + 1);
            chk("if10_latency", W, lat, W + 2);
            xfer(1'b1, 1'b0, 8'(MAXA + 1), 8'h00, lat, strb, gdel, err, rd);
            chk("oob_strobes", W, strb, 0);
            chk("oob_err", W, err, 1);
            chk("oob_latency", W, lat, W + 2);

            for (int c = 0; c < 400; c++) begin
                cycle();
                drive_random();
            end
            if_req = 1'b0; ls_req = 1'b0;
            repeat (W + 4) cycle();

            // Reset in the second cycle of a write must drop mwr at once.
            ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h05; ls_wdata = 8'h3C;
            for (int c = 0; c < 20 && !ls_gnt; c++) cycle();
            chk("rstmid_gnt", W, ls_gnt, 1);
            cycle();
            chk("rstmid_mwr_before", W, mwr, (W >= 1) ? 1 : 0);
            rst = 1'b1;
            #1;
            chk("rstmid_mwr_async", W, mwr, 0);
            chk("rstmid_mrd_async", W, mrd, 0);
            model_reset();
            repeat (2) cycle();
            rst = 1'b0;
            xfer(1'b1, 1'b0, 8'h05, 8'h00, lat, strb, gdel, err, rd);
            chk("post_rst_idle_grant", W, gdel, 1);
            chk("post_rst_latency", W, lat, W + 2);
            chk("post_rst_data", W, rd, 8'h3C);
            repeat (3) cycle();
            done_i = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 20000 && !all_done; t++) begin
            #10;
            all_done = g_inst[0].done_i && g_inst[1].done_i && g_inst[2].done_i;
        end
        if (!all_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bench_timeout: got not-done, want all instances done");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
